// File: rtl/str_to_num_multi.sv
// ASCII byte-stream to binary number converter.
// Parses decimal tokens, optional leading '-' (two's complement result) and
// optional "0x"/"0X" hex prefix; one result per token on a valid/ready port.
// Magnitude overflow beyond WIDTH bits is flagged per token; the value wraps.
module str_to_num_multi #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1,
  parameter bit HEX_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_dtm,
  input  logic             s_vld,
  output logic             s_rdy,
  output logic [WIDTH-1:0] n_dtm,
  output logic             n_ovf,
  output logic             n_vld,
  input  logic             n_rdy
);

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_LA    = 8'h61;
  localparam logic [7:0] CH_LF    = 8'h66;
  localparam logic [7:0] CH_UA    = 8'h41;
  localparam logic [7:0] CH_UF    = 8'h46;
  localparam logic [7:0] CH_LX    = 8'h78;
  localparam logic [7:0] CH_UX    = 8'h58;
  localparam logic [7:0] CH_MINUS = 8'h2D;

  typedef enum logic [2:0] {
    WAIT   = 3'd0,
    SIGN   = 3'd1,
    ZERO   = 3'd2,
    DIGITS = 3'd3,
    SEND   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic             neg, hex, ovf;

  logic             hs;
  logic             is_dec, is_let, is_x, is_minus, dig_ok;
  logic [3:0]       dval;
  logic [WIDTH+3:0] step;

  assign hs = s_vld && s_rdy;

  // Classify the incoming byte and derive its digit value
  always_comb begin
    is_dec   = (s_dtm >= CH_0) && (s_dtm <= CH_9);
    is_let   = ((s_dtm >= CH_LA) && (s_dtm <= CH_LF)) ||
               ((s_dtm >= CH_UA) && (s_dtm <= CH_UF));
    // letters a-f / A-F share low nibble 1..6, so +9 gives 10..15
    dval     = is_let ? (s_dtm[3:0] + 4'd9) : s_dtm[3:0];
    dig_ok   = is_dec || (hex && is_let);
    is_x     = (s_dtm == CH_LX) || (s_dtm == CH_UX);
    is_minus = SIGNED_EN && (s_dtm == CH_MINUS);
  end

  // Next accumulator value in WIDTH+4 bits; shift-add multiply by base
  always_comb begin
    if (hex)
      step = {acc, 4'b0000} + {{WIDTH{1'b0}}, dval};
    else
      step = {1'b0, acc, 3'b000} + {3'b000, acc, 1'b0} + {{WIDTH{1'b0}}, dval};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= WAIT;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT, SIGN: begin
        if (hs) begin
          if (is_dec)
            state_nxt = (HEX_EN && (s_dtm == CH_0)) ? ZERO : DIGITS;
          else if ((state == WAIT) && is_minus)
            state_nxt = SIGN;
          else
            state_nxt = WAIT;
        end
      end
      ZERO: begin
        if (hs) state_nxt = (is_x || is_dec) ? DIGITS : SEND;
      end
      DIGITS: begin
        if (hs && !dig_ok) state_nxt = SEND;
      end
      SEND: begin
        if (n_rdy) state_nxt = WAIT;
      end
      default: state_nxt = WAIT;
    endcase
  end

  // Handshake outputs decode registered state only
  always_comb begin
    s_rdy = (state != SEND);
    n_vld = (state == SEND);
  end

  // Token datapath: accumulator, sign/base flags, sticky overflow, result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      neg   <= 1'b0;
      hex   <= 1'b0;
      ovf   <= 1'b0;
      n_dtm <= '0;
      n_ovf <= 1'b0;
    end else begin
      case (state)
        WAIT, SIGN: begin
          if (hs) begin
            if (is_dec) begin
              acc <= WIDTH'(dval);
              hex <= 1'b0;
            end else if ((state == WAIT) && is_minus) begin
              neg <= 1'b1;
            end else if (state == SIGN) begin
              // anything but a digit after '-' cancels the sign
              neg <= 1'b0;
            end
          end
        end
        ZERO: begin
          if (hs) begin
            if (is_x) begin
              hex <= 1'b1;
            end else if (is_dec) begin
              acc <= WIDTH'(dval);
            end else begin
              // lone "0": negating zero is still zero
              n_dtm <= '0;
              n_ovf <= ovf;
            end
          end
        end
        DIGITS: begin
          if (hs) begin
            if (dig_ok) begin
              acc <= step[WIDTH-1:0];
              ovf <= ovf | (|step[WIDTH+3:WIDTH]);
            end else begin
              n_dtm <= neg ? ((~acc) + WIDTH'(1)) : acc;
              n_ovf <= ovf;
            end
          end
        end
        SEND: begin
          if (n_rdy) begin
            acc <= '0;
            neg <= 1'b0;
            hex <= 1'b0;
            ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_str_to_num_multi.sv
// Bench for str_to_num_multi: directed handshake/reset checks on a 32-bit
// signed+hex instance, then random byte streams on that instance and on an
// 8-bit decimal-only instance, scored against a token-level reference model.
module tb_str_to_num_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_dtm [2];
  logic        s_vld [2];
  logic        s_rdy [2];
  logic        n_vld [2];
  logic        n_ovf [2];
  logic        n_rdy [2];
  logic [31:0] n_dtm_a;
  logic [7:0]  n_dtm_b;

  int vecs = 0;
  int errs = 0;

  bit [7:0] stim  [$];
  longint   exp_v [$];
  bit       exp_o [$];

  always #5 clk = ~clk;

  str_to_num_multi #(.WIDTH(32), .SIGNED_EN(1'b1), .HEX_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_dtm(s_dtm[0]), .s_vld(s_vld[0]), .s_rdy(s_rdy[0]),
    .n_dtm(n_dtm_a), .n_ovf(n_ovf[0]), .n_vld(n_vld[0]), .n_rdy(n_rdy[0])
  );

  str_to_num_multi #(.WIDTH(8), .SIGNED_EN(1'b0), .HEX_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_dtm(s_dtm[1]), .s_vld(s_vld[1]), .s_rdy(s_rdy[1]),
    .n_dtm(n_dtm_b), .n_ovf(n_ovf[1]), .n_vld(n_vld[1]), .n_rdy(n_rdy[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ndtm(input int d);
    return (d == 0) ? n_dtm_a : {24'h0, n_dtm_b};
  endfunction

  // digit value of c in the given base, -1 if not a digit
  function automatic int dig(input bit [7:0] c, input int base);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (base == 16 && c >= "a" && c <= "f") return int'(c) - 97 + 10;
    if (base == 16 && c >= "A" && c <= "F") return int'(c) - 65 + 10;
    return -1;
  endfunction

  // Scan the whole stream into expected (value, overflow) tokens.
  function automatic void model(input int w, input bit sg, input bit hx);
    longint   lim;
    longint   m;
    int       i, n, base;
    bit       big, neg;
    bit [7:0] c;
    lim = longint'(1) << w;
    i = 0;
    n = stim.size();
    exp_v.delete();
    exp_o.delete();
    while (i < n) begin
      c = stim[i]; i++;
      neg = 1'b0;
      if (sg && c == "-") begin
        if (i >= n) break;
        c = stim[i]; i++;
        if (dig(c, 10) < 0) continue;
        neg = 1'b1;
      end
      if (dig(c, 10) < 0) continue;
      base = 10;
      m    = dig(c, 10);
      big  = 1'b0;
      if (hx && c == "0" && i < n && (stim[i] == "x" || stim[i] == "X")) begin
        base = 16;
        i++;
      end
      while (i < n && dig(stim[i], base) >= 0) begin
        m = m * base + dig(stim[i], base);
        i++;
        if (m >= lim) begin
          big = 1'b1;
          m   = m % lim;
        end
      end
      if (i >= n) break;
      i++;
      exp_v.push_back(neg ? ((lim - m) % lim) : m);
      exp_o.push_back(big);
    end
  endfunction

  function automatic void push_str(input string s);
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endfunction

  task automatic add_random(input int ntok, input int maxlen);
    string decs = "0123456789";
    string hexs = "0123456789abcdefABCDEF";
    string junk = "xX-gz ,;:0a";
    string seps = " ,;\n.";
    int    kind, len;
    for (int t = 0; t < ntok; t++) begin
      kind = int'($urandom_range(3));
      len  = int'($urandom_range(maxlen, 1));
      case (kind)
        0: begin
          if ($urandom_range(1) == 1) stim.push_back("-");
          for (int j = 0; j < len; j++) stim.push_back(decs[$urandom_range(9)]);
        end
        1: begin
          stim.push_back("0");
          stim.push_back(($urandom_range(1) == 1) ? "x" : "X");
          for (int j = 0; j < len; j++) stim.push_back(hexs[$urandom_range(21)]);
        end
        2: begin
          for (int j = 0; j < len; j++) stim.push_back(junk[$urandom_range(10)]);
        end
        default: begin
          for (int j = 0; j < len; j++) stim.push_back(decs[$urandom_range(9)]);
        end
      endcase
      stim.push_back(seps[$urandom_range(4)]);
    end
  endtask

  // Random valid / ready pacing; scores every output transfer in order.
  task automatic run_stream(input int d, input int w, input bit sg, input bit hx);
    int          idx, got, cyc;
    bit          hold;
    logic [31:0] held;
    idx  = 0;
    got  = 0;
    cyc  = 0;
    hold = 1'b0;
    held = '0;
    model(w, sg, hx);
    while ((idx < stim.size() || got < exp_v.size()) && cyc < 40000) begin
      s_vld[d] = (idx < stim.size()) && ($urandom_range(3) != 0);
      s_dtm[d] = (idx < stim.size()) ? stim[idx] : 8'($urandom);
      n_rdy[d] = ($urandom_range(2) != 0);
      chk("rdy_vs_vld", s_rdy[d], !n_vld[d]);
      if (n_vld[d]) begin
        if (hold) chk("hold", ndtm(d), held);
        if (got < exp_v.size()) begin
          if (n_rdy[d]) begin
            chk("value", ndtm(d), exp_v[got]);
            chk("ovf", n_ovf[d], exp_o[got]);
            got++;
          end
        end else begin
          chk("extra_out", n_vld[d], 1'b0);
        end
        hold = !n_rdy[d];
        held = ndtm(d);
      end else begin
        hold = 1'b0;
      end
      if (s_vld[d] && s_rdy[d]) idx++;
      @(negedge clk);
      cyc++;
    end
    s_vld[d] = 1'b0;
    n_rdy[d] = 1'b0;
    chk("stream_tokens", got, exp_v.size());
    chk("stream_bytes", idx, stim.size());
  endtask

  // Offer one byte to instance A and hold it until accepted.
  task automatic push(input bit [7:0] c);
    int b;
    b = 0;
    s_vld[0] = 1'b1;
    s_dtm[0] = c;
    while (!s_rdy[0] && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (!s_rdy[0]) chk("push_timeout", s_rdy[0], 1'b1);
    @(negedge clk);
    s_vld[0] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      s_vld[d] = 1'b0;
      s_dtm[d] = 8'h00;
      n_rdy[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_vld", n_vld[0], 1'b0);
    chk("rst_rdy", s_rdy[0], 1'b1);
    chk("rst_dtm", n_dtm_a, 32'h0);
    chk("rst_ovf", n_ovf[0], 1'b0);

    // latency: n_vld rises the cycle after the terminator
    push("1"); push("2"); push("3");
    chk("lat_pre", n_vld[0], 1'b0);
    push("\n");
    chk("lat_vld", n_vld[0], 1'b1);
    chk("lat_dtm", n_dtm_a, 32'd123);

    // backpressure with a byte waiting
    s_vld[0] = 1'b1;
    s_dtm[0] = "9";
    for (int k = 0; k < 5; k++) begin
      chk("bp_rdy", s_rdy[0], 1'b0);
      chk("bp_vld", n_vld[0], 1'b1);
      chk("bp_dtm", n_dtm_a, 32'd123);
      @(negedge clk);
    end
    n_rdy[0] = 1'b1;
    @(negedge clk);
    n_rdy[0] = 1'b0;
    chk("bp_post_vld", n_vld[0], 1'b0);
    chk("bp_post_rdy", s_rdy[0], 1'b1);
    @(negedge clk);
    s_dtm[0] = ",";
    @(negedge clk);
    s_vld[0] = 1'b0;
    chk("bp_next_vld", n_vld[0], 1'b1);
    chk("bp_next_dtm", n_dtm_a, 32'd9);
    n_rdy[0] = 1'b1;
    @(negedge clk);
    n_rdy[0] = 1'b0;

    // reset mid-token discards the partial number
    push("9"); push("8");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push("7"); push(",");
    chk("rmid_vld", n_vld[0], 1'b1);
    chk("rmid_dtm", n_dtm_a, 32'd7);
    n_rdy[0] = 1'b1;
    @(negedge clk);
    n_rdy[0] = 1'b0;

    // reset during SEND drops the output without a transfer
    push("5"); push(",");
    chk("rsend_vld_pre", n_vld[0], 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rsend_vld", n_vld[0], 1'b0);
    chk("rsend_dtm", n_dtm_a, 32'h0);
    chk("rsend_rdy", s_rdy[0], 1'b1);

    // 32-bit signed/hex instance: directed tokens then random ones
    stim.delete();
    push_str("123\n-42 --7 0x1aF;0,0x,4294967296,5,-0X10,0,4294967295,");
    add_random(80, 12);
    push_str("\n\n");
    run_stream(0, 32, 1'b1, 1'b1);

    // 8-bit decimal-only instance
    stim.delete();
    push_str("0x1F 255,256,-3 x9a,0,");
    add_random(60, 4);
    push_str("\n\n");
    run_stream(1, 8, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
